// File: rtl/sha3_pkg.sv
// SHA3 padder shared definitions: mode encoding, rate table, domain bytes.
// Imported by the padder top and the keep checker.
package sha3_pkg;

    localparam int MAX_RATE_BYTES = 168;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } sha3_mode_t;

    // Unused encodings 6/7 fall back to the SHA3-256 rate.
    localparam logic [7:0] RATE_BYTES [8] = '{
        8'd144, 8'd136, 8'd104, 8'd72,
        8'd168, 8'd136, 8'd136, 8'd136
    };

    function automatic logic [7:0] domain_of(input logic [2:0] mode);
        if (sha3_mode_t'(mode) == MODE_SHAKE128 ||
            sha3_mode_t'(mode) == MODE_SHAKE256)
            return DOMAIN_SHAKE;
        return DOMAIN_SHA3;
    endfunction

endpackage

// File: rtl/axis_keep_check.sv
// Combinational TKEEP qualifier: byte count to write and protocol-error flag.
// Ports: i_keep (byte enables), i_last (beat is last) -> o_count, o_err.
module axis_keep_check
    import sha3_pkg::*;
#(
    parameter int DB = 4
) (
    input  logic [DB-1:0] i_keep,
    input  logic          i_last,
    output logic [7:0]    o_count,
    output logic          o_err
);

    logic          w_run;
    logic [DB-1:0] w_mask;
    logic [7:0]    w_cnt;

    // w_mask is the contiguous run of ones starting at bit 0.
    always_comb begin
        w_run  = 1'b1;
        w_mask = '0;
        w_cnt  = '0;
        for (int i = 0; i < DB; i++) begin
            if (w_run && i_keep[i]) begin
                w_mask[i] = 1'b1;
                w_cnt     = w_cnt + 8'd1;
            end else begin
                w_run = 1'b0;
            end
        end
        if (i_last) begin
            o_count = w_cnt;
            o_err   = (i_keep != w_mask);
        end else begin
            o_count = 8'(DB);
            o_err   = (i_keep != {DB{1'b1}});
        end
    end

endmodule

// File: rtl/axis_sha3_padder.sv
// AXI-Stream byte message -> Keccak pad10*1 padded rate-sized blocks.
// Ports: ACLK/ARESET, s_axis_* message in, m_blk_* block out, prot_err pulse.
module axis_sha3_padder
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_RATE_BYTES = 168
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [2:0]                  s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [8*MAX_RATE_BYTES-1:0] m_blk_data,
    output logic [7:0]                  m_blk_rate,
    output logic                        m_blk_last,
    output logic                        m_blk_valid,
    input  logic                        m_blk_ready,
    output logic                        prot_err
);

    localparam int DB = DATA_WIDTH / 8;
    localparam int BW = 8 * MAX_RATE_BYTES;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_EXTRA = 3'd4;

    logic [2:0]    r_state;
    logic [7:0]    r_ptr;
    logic [7:0]    r_rate;
    logic [7:0]    r_dom;
    logic [BW-1:0] r_buf;
    logic          r_last;
    logic          r_extra;
    logic          r_err;

    logic          w_idle;
    logic          w_accept;
    logic [7:0]    w_rate;
    logic [7:0]    w_dom;
    logic [7:0]    w_cnt;
    logic          w_kerr;
    logic [7:0]    w_nptr;
    logic [BW-1:0] w_padded;
    logic [BW-1:0] w_extra;

    axis_keep_check #(.DB(DB)) u_keep (
        .i_keep  (s_axis_tkeep),
        .i_last  (s_axis_tlast),
        .o_count (w_cnt),
        .o_err   (w_kerr)
    );

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = s_axis_tvalid & s_axis_tready;
    // Mode is taken from tuser only on the first beat of a message.
    assign w_rate   = w_idle ? RATE_BYTES[s_axis_tuser] : r_rate;
    assign w_dom    = w_idle ? domain_of(s_axis_tuser) : r_dom;
    assign w_nptr   = r_ptr + w_cnt;

    // Padded current block, and the pad-only block used when the
    // message ended exactly on a block boundary.
    always_comb begin
        w_padded = r_buf;
        w_extra  = '0;
        if (r_ptr < r_rate) begin
            w_padded[int'(r_ptr)*8 +: 8] =
                r_buf[int'(r_ptr)*8 +: 8] ^ r_dom;
            w_padded[(int'(r_rate)-1)*8 +: 8] =
                w_padded[(int'(r_rate)-1)*8 +: 8] | 8'h80;
        end
        if (r_rate != 8'd0) begin
            w_extra[7:0] = r_dom;
            w_extra[(int'(r_rate)-1)*8 +: 8] = 8'h80;
        end
    end

    assign s_axis_tready = ((r_state == S_IDLE) || (r_state == S_FILL))
                           && !ARESET;
    assign m_blk_valid   = (r_state == S_EMIT) || (r_state == S_EXTRA);
    assign m_blk_data    = r_buf;
    assign m_blk_rate    = r_rate;
    assign m_blk_last    = r_last;
    assign prot_err      = r_err;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_rate  <= '0;
            r_dom   <= '0;
            r_buf   <= '0;
            r_last  <= 1'b0;
            r_extra <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE, S_FILL: begin
                    if (w_accept) begin
                        r_rate <= w_rate;
                        r_dom  <= w_dom;
                        r_err  <= w_kerr;
                        for (int k = 0; k < DB; k++) begin
                            if (k < int'(w_cnt))
                                r_buf[(int'(r_ptr)+k)*8 +: 8] <=
                                    s_axis_tdata[k*8 +: 8];
                        end
                        r_ptr <= w_nptr;
                        if (s_axis_tlast) begin
                            r_state <= S_PAD;
                        end else if (w_nptr == w_rate) begin
                            r_state <= S_EMIT;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    // A full final block needs a separate pad-only block.
                    if (r_ptr < r_rate) begin
                        r_buf   <= w_padded;
                        r_last  <= 1'b1;
                        r_extra <= 1'b0;
                    end else begin
                        r_last  <= 1'b0;
                        r_extra <= 1'b1;
                    end
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (m_blk_ready) begin
                        r_ptr <= '0;
                        if (r_extra) begin
                            r_buf   <= w_extra;
                            r_extra <= 1'b0;
                            r_last  <= 1'b1;
                            r_state <= S_EXTRA;
                        end else if (r_last) begin
                            r_buf   <= '0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_buf   <= '0;
                            r_state <= S_FILL;
                        end
                    end
                end
                S_EXTRA: begin
                    if (m_blk_ready) begin
                        r_buf   <= '0;
                        r_last  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_sha3_padder.sv
// Directed bench for axis_sha3_padder: padding, block split, backpressure,
// reset recovery and tkeep protocol errors against a reference block model.
module tb_axis_sha3_padder;

    localparam int DW  = 32;
    localparam int DB  = DW / 8;
    localparam int MRB = 168;
    localparam int BW  = 8 * MRB;

    logic           ACLK;
    logic           ARESET;
    logic [DW-1:0]  s_axis_tdata;
    logic [DB-1:0]  s_axis_tkeep;
    logic [2:0]     s_axis_tuser;
    logic           s_axis_tlast;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [BW-1:0]  m_blk_data;
    logic [7:0]     m_blk_rate;
    logic           m_blk_last;
    logic           m_blk_valid;
    logic           m_blk_ready;
    logic           prot_err;

    axis_sha3_padder #(.DATA_WIDTH(DW), .MAX_RATE_BYTES(MRB)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_blk_data    (m_blk_data),
        .m_blk_rate    (m_blk_rate),
        .m_blk_last    (m_blk_last),
        .m_blk_valid   (m_blk_valid),
        .m_blk_ready   (m_blk_ready),
        .prot_err      (prot_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [BW-1:0] d;
        logic [7:0]    r;
        logic          l;
    } blk_t;

    blk_t       q[$];
    blk_t       blks[$];
    logic [7:0] msg[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         perr_n = 0;

    always @(negedge ACLK) begin
        if (!ARESET && m_blk_valid && m_blk_ready)
            q.push_back('{m_blk_data, m_blk_rate, m_blk_last});
        if (prot_err)
            perr_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rate_of(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            4: return 168;
            default: return 136;
        endcase
    endfunction

    function automatic logic [7:0] dom_of(input int m);
        return (m == 4 || m == 5) ? 8'h1F : 8'h06;
    endfunction

    // Caller is at a negedge; returns at the negedge after acceptance.
    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k,
                              input int m, input logic l);
        int w = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = 3'(m);
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && w < 1000) begin
            @(negedge ACLK);
            w++;
        end
        chk("beat_accept", {63'b0, s_axis_tready}, 64'd1);
        @(negedge ACLK);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_msg(input int m);
        int n  = msg.size();
        int nb = (n == 0) ? 1 : (n + DB - 1) / DB;
        for (int b = 0; b < nb; b++) begin
            logic [31:0] d = '0;
            logic [3:0]  k = '0;
            for (int j = 0; j < DB; j++) begin
                if (b*DB + j < n) begin
                    d[j*8 +: 8] = msg[b*DB + j];
                    k[j] = 1'b1;
                end
            end
            drive_beat(d, k, m, b == nb - 1);
        end
    endtask

    // Reference pad10*1 over msg, compared block by block.
    task automatic check_msg(input string tag, input int m);
        int n    = msg.size();
        int r    = rate_of(m);
        int nblk = n / r + 1;
        int w    = 0;
        logic [7:0] p[$];
        blks.delete();
        for (int i = 0; i < nblk*r; i++)
            p.push_back(i < n ? msg[i] : 8'h00);
        p[n] = p[n] ^ dom_of(m);
        p[nblk*r-1] = p[nblk*r-1] | 8'h80;
        while (q.size() < nblk && w < 2000) begin
            @(negedge ACLK);
            w++;
        end
        chk({tag, "_nblk"}, 64'(q.size()), 64'(nblk));
        for (int i = 0; i < nblk; i++) begin
            blk_t b;
            logic [BW-1:0] e = '0;
            int f = 0;
            if (q.size() == 0) break;
            b = q.pop_front();
            blks.push_back(b);
            for (int j = 0; j < r; j++) e[j*8 +: 8] = p[i*r + j];
            for (int j = 0; j < MRB; j++) begin
                if (b.d[j*8 +: 8] !== e[j*8 +: 8]) begin
                    f = j;
                    break;
                end
            end
            chk($sformatf("%s_b%0d_rate", tag, i), 64'(b.r), 64'(r));
            chk($sformatf("%s_b%0d_last", tag, i), 64'(b.l),
                64'(i == nblk - 1));
            chk($sformatf("%s_b%0d_byte%0d", tag, i, f),
                64'(b.d[f*8 +: 8]), 64'(e[f*8 +: 8]));
        end
    endtask

    task automatic fill_msg(input int n, input int seed);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(i*7 + seed));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0;
        logic [BW-1:0] snap;
        ARESET        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_blk_ready   = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_tready", {63'b0, s_axis_tready}, 64'd0);
        chk("rst_valid", {63'b0, m_blk_valid}, 64'd0);
        chk("rst_rate", 64'(m_blk_rate), 64'd0);
        chk("rst_last", {63'b0, m_blk_last}, 64'd0);
        chk("rst_data", {63'b0, |m_blk_data}, 64'd0);
        chk("rst_err", {63'b0, prot_err}, 64'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("idle_tready", {63'b0, s_axis_tready}, 64'd1);

        // 1: empty SHA3-256 message, tlast->valid latency of 2.
        msg.delete();
        drive_beat(32'h0, 4'b0000, 1, 1'b1);
        chk("t1_lat_pad", {63'b0, m_blk_valid}, 64'd0);
        @(negedge ACLK);
        chk("t1_lat_emit", {63'b0, m_blk_valid}, 64'd1);
        chk("t1_tready", {63'b0, s_axis_tready}, 64'd0);
        check_msg("t1", 1);
        chk("t1_b0", 64'(blks[0].d[7:0]), 64'h06);
        chk("t1_b135", 64'(blks[0].d[135*8 +: 8]), 64'h80);

        // 2: SHA3-512, 71 bytes, pad lands in the last rate byte.
        fill_msg(71, 3);
        send_msg(3);
        check_msg("t2", 3);
        chk("t2_b71", 64'(blks[0].d[71*8 +: 8]), 64'h86);

        // 3: SHA3-384, exactly one rate of data -> extra pad block.
        fill_msg(104, 9);
        send_msg(2);
        check_msg("t3", 2);
        chk("t3_x_b0", 64'(blks[1].d[7:0]), 64'h06);
        chk("t3_x_b103", 64'(blks[1].d[103*8 +: 8]), 64'h80);

        // 4: SHAKE128 "abc".
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(4);
        check_msg("t4", 4);
        chk("t4_b0_2", 64'(blks[0].d[23:0]), 64'h636261);
        chk("t4_b3", 64'(blks[0].d[31:24]), 64'h1F);
        chk("t4_b167", 64'(blks[0].d[167*8 +: 8]), 64'h80);

        // 5: SHA3-224, 300 bytes, 5 cycles of output backpressure.
        @(posedge ACLK); #1 m_blk_ready = 1'b0;
        @(negedge ACLK);
        fill_msg(300, 21);
        fork
            send_msg(0);
            begin
                int w = 0;
                while (!m_blk_valid && w < 500) begin
                    @(negedge ACLK);
                    w++;
                end
                chk("t5_valid", {63'b0, m_blk_valid}, 64'd1);
                snap = m_blk_data;
                repeat (5) begin
                    @(negedge ACLK);
                    chk("t5_hold", {63'b0, m_blk_data == snap}, 64'd1);
                    chk("t5_tready", {63'b0, s_axis_tready}, 64'd0);
                end
                @(posedge ACLK); #1 m_blk_ready = 1'b1;
            end
        join
        check_msg("t5", 0);
        chk("t5_b12", 64'(blks[2].d[12*8 +: 8]), 64'h06);

        // 6: reset mid-message, then a clean 1-byte message.
        drive_beat(32'h11111111, 4'hF, 1, 1'b0);
        drive_beat(32'h22222222, 4'hF, 1, 1'b0);
        drive_beat(32'h33333333, 4'hF, 1, 1'b0);
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("t6_valid", {63'b0, m_blk_valid}, 64'd0);
        chk("t6_tready", {63'b0, s_axis_tready}, 64'd1);
        q.delete();
        msg.delete();
        msg.push_back(8'hA5);
        send_msg(1);
        check_msg("t6", 1);
        chk("t6_b1", 64'(blks[0].d[15:8]), 64'h06);

        // 7: non-last beat with partial tkeep -> error, all 4 bytes kept.
        pe0 = perr_n;
        drive_beat(32'h44332211, 4'b0011, 1, 1'b0);
        drive_beat(32'h88776655, 4'b1111, 1, 1'b1);
        msg.delete();
        for (int i = 1; i <= 8; i++) msg.push_back(8'(i * 17));
        check_msg("t7", 1);
        chk("t7_b8", 64'(blks[0].d[8*8 +: 8]), 64'h06);
        chk("t7_perr", 64'(perr_n - pe0), 64'd1);

        // 8: non-contiguous last tkeep -> only low run used, error.
        pe0 = perr_n;
        drive_beat(32'hDDCCBBAA, 4'b0101, 1, 1'b1);
        msg.delete();
        msg.push_back(8'hAA);
        check_msg("t8", 1);
        chk("t8_perr", 64'(perr_n - pe0), 64'd1);

        // 9: SHAKE256 ending one byte short of the rate -> 0x9F.
        fill_msg(135, 5);
        send_msg(5);
        check_msg("t9", 5);
        chk("t9_b135", 64'(blks[0].d[135*8 +: 8]), 64'h9F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
